midi_tx: RTL and testbench
==========================

// Module: midi_tx
// PURPOSE
//   Serial MIDI transmitter; the counterpart of the synth's MIDI receiver. Accepts note-on/note-off
//   events over a valid/ready handshake and encodes them as MIDI messages. Serialises them as
//   8N1 UART at MIDI baud on a single idle-high line, with optional running-status compression.
//   Used for MIDI-thru, for sequencer output, and as the stimulus source for receiver loopback tests.
// PARAMETERS
//   CLK_FREQ        100_000_000  system clock frequency, Hz
//   BAUD_RATE       31_250       serial bit rate; CPB = CLK_FREQ/BAUD_RATE clocks per bit (integer, >=2)
//   RUNNING_STATUS  1            1: omit status byte when equal to last sent status; 0: always send it
// PORTS
//   clk           in   1  system clock
//   rst           in   1  synchronous, active-high reset
//   msg_valid     in   1  event present on msg_* fields
//   msg_ready     out  1  transmitter idle, event accepted when msg_valid && msg_ready
//   msg_on        in   1  1 = note-on (0x9n), 0 = note-off (0x8n)
//   msg_channel   in   4  MIDI channel n
//   msg_note      in   7  note number 0..127
//   msg_velocity  in   7  velocity 0..127 (sent unmodified; note-on vel 0 not rewritten)
//   data_out      out  1  serial MIDI line, idle high
//   busy          out  1  high from accept until last stop bit completes
//   msg_done      out  1  one-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//   Reset: data_out=1, msg_ready=0, busy=0, msg_done=0, running status invalid, FSM IDLE.
//     msg_ready rises in the first cycle with rst low. All outputs are registered.
//   Handshake: on accept at edge N, latch all msg_* fields. msg_ready=0 and busy=1 from cycle N+1.
//     msg_* changes after accept have no effect. msg_valid while not ready is held off, not dropped.
//   Status byte S = {msg_on ? 4'h9 : 4'h8, msg_channel}.
//     S is sent when RUNNING_STATUS=0, or last_status invalid, or S != last_status.
//     After S is sent, last_status <= S. Message = [S,] note, velocity: 3 or 2 bytes.
//   Byte frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit holds data_out for exactly CPB cycles.
//     The first start bit begins at cycle N+1.
//     Bytes are back-to-back, with no idle gap between the stop bit and the next start bit.
//   Completion: msg_done=1 in the last cycle of the final stop bit.
//     In the next cycle: busy=0, msg_ready=1, data_out=1.
//     Message time is 30*CPB cycles for 3 bytes, 20*CPB for 2 bytes.
//   Back-to-back: a msg_valid already high when ready rises is accepted that cycle. Its start bit
//     follows after exactly one idle-high cycle.
//   FSM: IDLE -> (accept) LOAD_STATUS | LOAD_NOTE -> SEND -> LOAD_NOTE -> SEND -> LOAD_VEL -> SEND -> IDLE.
//     LOAD_* states are zero-cycle decisions folded into the byte sequencer (byte index 0..2, start index 0 or 1).
//   Reset mid-operation: in the cycle after rst is sampled high, data_out=1 and the frame is
//     abandoned (no partial completion, no msg_done). last_status is invalidated, so the next
//     message always carries its status byte.
//   Bit timer: counts 0..CPB-1 and wraps to 0 at each bit boundary. The bit counter runs 0..9.
//     Both are cleared on reset and on each byte load.
// STRUCTURE
//   midi_pkg: MIDI_STATUS_NOTE_ON=4'h9, MIDI_STATUS_NOTE_OFF=4'h8, MIDI_BAUD=31_250,
//     typedef struct packed {logic on; logic [3:0] channel; logic [6:0] note, velocity;} midi_note_msg_t
//     (shared with the receiver).
//   Sub-module midi_uart_tx #(CPB): byte_valid/byte_ready/byte_in -> data_out 8N1 serialiser.
//     midi_tx holds the handshake, running-status register and byte-sequencer FSM.
// TESTING (sim with CLK_FREQ=312_500, BAUD_RATE=31_250 -> CPB=10; bench decodes data_out as UART)
//   Note-on ch0 note 60 vel 100 -> bytes 0x90,0x3C,0x64.
//     Start bit at cycle N+1. msg_done at N+300. ready high at N+301.
//   Repeat note-on ch0 note 64 vel 64 -> only 0x40,0x40 (200 cycles).
//     Then note-off ch0 note 64 vel 0 -> 0x80,0x40,0x00.
//   RUNNING_STATUS=0, two identical note-on ch3 note 1 vel 1 -> 0x93,0x01,0x01 both times.
//   msg_valid held high, fields toggled every cycle during transmission.
//     -> msg_ready stays low and bytes match the values latched at accept.
//     The second message's start bit follows exactly one idle cycle.
//   rst pulsed at cycle N+55 (mid-byte 0) -> data_out=1 next cycle, no msg_done.
//     ready rises after rst drops. Re-sending the same note-on emits status 0x90 again.
//   Note-off ch15 note 127 vel 0 -> 0x8F,0x7F,0x00. Each frame has start=0, stop=1, 10*CPB wide.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: MIDI constants and types, shared by the transmitter and the receiver.
//   MIDI_STATUS_NOTE_ON / MIDI_STATUS_NOTE_OFF : upper status nibble
//   MIDI_BAUD       : standard MIDI serial bit rate
//   midi_note_msg_t : one note-on/note-off event
//   midi_tx_state_t : transmitter byte-sequencer states
//   midi_status()   : status byte for an event
package midi_pkg;

  localparam logic [3:0] MIDI_STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_STATUS_NOTE_OFF = 4'h8;
  localparam int         MIDI_BAUD            = 31_250;

  typedef struct packed {
    logic       on;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
  } midi_note_msg_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } midi_tx_state_t;

  function automatic logic [7:0] midi_status(input midi_note_msg_t m);
    return {(m.on ? MIDI_STATUS_NOTE_ON : MIDI_STATUS_NOTE_OFF), m.channel};
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// midi_tx_if: note-event handshake into the MIDI transmitter.
//   msg_valid    : event present on the msg_* fields (source -> transmitter)
//   msg_ready    : transmitter can accept an event (transmitter -> source)
//   msg_on       : 1 = note-on, 0 = note-off
//   msg_channel  : MIDI channel 0..15
//   msg_note     : note number 0..127
//   msg_velocity : velocity 0..127
interface midi_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic       msg_on;
  logic [3:0] msg_channel;
  logic [6:0] msg_note;
  logic [6:0] msg_velocity;

  modport master (
    output msg_valid, msg_on, msg_channel, msg_note, msg_velocity,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_on, msg_channel, msg_note, msg_velocity,
    output msg_ready
  );
endinterface

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 serialiser, CPB clocks per bit.
//   clk, rst   : system clock, synchronous active-high reset
//   byte_valid : byte_in is offered for transmission
//   byte_in    : byte to send, LSB first
//   byte_ready : a load happens this cycle if byte_valid (idle, or last cycle of a stop bit)
//   stop_next  : the coming cycle is the last cycle of the current stop bit
//   data_out   : serial line, idle high, registered
module midi_uart_tx #(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_ready,
  output logic       stop_next,
  output logic       data_out
);

  localparam int            TW     = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CPB - 2);

  logic          active;
  logic [7:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          last_tick;

  assign last_tick  = (timer == T_LAST);
  // Accepting in the last stop-bit cycle makes frames abut with no idle gap.
  assign byte_ready = !active || (bit_cnt == 4'd9 && last_tick);
  assign stop_next  = active && (bit_cnt == 4'd9) && (timer == T_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      shreg    <= 8'hFF;
      bit_cnt  <= 4'd0;
      timer    <= '0;
      data_out <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      active   <= 1'b1;
      shreg    <= byte_in;
      bit_cnt  <= 4'd0;
      timer    <= '0;
      data_out <= 1'b0;
    end else if (active) begin
      if (last_tick) begin
        timer <= '0;
        if (bit_cnt == 4'd9) begin
          active   <= 1'b0;
          data_out <= 1'b1;
        end else begin
          // Shifting in ones means the ninth boundary naturally yields the stop bit.
          bit_cnt  <= bit_cnt + 4'd1;
          data_out <= shreg[0];
          shreg    <= {1'b1, shreg[7:1]};
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: MIDI note-on/note-off transmitter with optional running status.
//   clk, rst : system clock, synchronous active-high reset
//   msg      : event handshake (midi_tx_if.slave)
//   data_out : serial MIDI line, 8N1, idle high
//   busy     : high from accept until the last stop bit completes
//   msg_done : one-cycle pulse in the final cycle of the last stop bit
//
// state   | meaning
// TX_IDLE | line idle; msg_ready high one cycle after reset releases; accept loads first byte
// TX_SEND | byte_idx 0=status 1=note 2=velocity in flight; next byte loads at stop-bit end
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = MIDI_BAUD,
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk,
  input  logic       rst,
  midi_tx_if.slave   msg,
  output logic       data_out,
  output logic       busy,
  output logic       msg_done
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;

  midi_tx_state_t state_q, state_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [6:0]     note_q, vel_q;
  logic [7:0]     status_q;
  logic           status_vld_q;
  logic           ready_q, busy_q, done_q;

  midi_note_msg_t in_msg;
  logic [7:0]     in_status;
  logic           send_status;
  logic           accept;
  logic           byte_valid, byte_ready, stop_next;
  logic [7:0]     byte_in;

  assign in_msg      = {msg.msg_on, msg.msg_channel, msg.msg_note, msg.msg_velocity};
  assign in_status   = midi_status(in_msg);
  assign accept      = (state_q == TX_IDLE) && ready_q && msg.msg_valid;
  assign send_status = (RUNNING_STATUS == 0) || !status_vld_q || (in_status != status_q);

  assign msg.msg_ready = ready_q;
  assign busy          = busy_q;
  assign msg_done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      byte_idx_q   <= 2'd0;
      note_q       <= '0;
      vel_q        <= '0;
      status_q     <= '0;
      status_vld_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      if (accept) begin
        note_q <= in_msg.note;
        vel_q  <= in_msg.velocity;
        // Any later reset invalidates this, so recording at accept is equivalent
        // to recording once the status byte is actually on the wire.
        if (send_status) begin
          status_q     <= in_status;
          status_vld_q <= 1'b1;
        end
      end
      ready_q <= (state_d == TX_IDLE);
      busy_q  <= (state_d == TX_SEND);
      done_q  <= (state_q == TX_SEND) && (byte_idx_q == 2'd2) && stop_next;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d    = TX_SEND;
          byte_idx_d = send_status ? 2'd0 : 2'd1;
        end
      end
      TX_SEND: begin
        if (byte_ready) begin
          if (byte_idx_q == 2'd2) state_d = TX_IDLE;
          else                    byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // The first byte is handed over in the accept cycle so its start bit begins right after.
  always_comb begin
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          byte_valid = 1'b1;
          byte_in    = send_status ? in_status : {1'b0, in_msg.note};
        end
      end
      TX_SEND: begin
        if (byte_ready && byte_idx_q != 2'd2) begin
          byte_valid = 1'b1;
          byte_in    = (byte_idx_q == 2'd0) ? {1'b0, note_q} : {1'b0, vel_q};
        end
      end
      default: ;
    endcase
  end

  midi_uart_tx #(.CPB(CPB)) u_uart (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .byte_ready (byte_ready),
    .stop_next  (stop_next),
    .data_out   (data_out)
  );

endmodule

// File: tb/tb_midi_tx.sv
module tb_midi_tx;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d0, b0, m0, d1, b1, m1;
  int   n_tests = 0;
  int   n_fail  = 0;

  midi_tx_if bus0 ();
  midi_tx_if bus1 ();

  midi_tx #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .RUNNING_STATUS(1)) dut0 (
    .clk(clk), .rst(rst), .msg(bus0.slave), .data_out(d0), .busy(b0), .msg_done(m0)
  );
  midi_tx #(.CLK_FREQ(312_500), .BAUD_RATE(31_250), .RUNNING_STATUS(0)) dut1 (
    .clk(clk), .rst(rst), .msg(bus1.slave), .data_out(d1), .busy(b1), .msg_done(m1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic on, input logic [3:0] ch, input logic [6:0] note,
                            input logic [6:0] vel);
    bus0.msg_on = on;  bus0.msg_channel = ch;  bus0.msg_note = note;  bus0.msg_velocity = vel;
    bus1.msg_on = on;  bus1.msg_channel = ch;  bus1.msg_note = note;  bus1.msg_velocity = vel;
  endtask

  task automatic wait_ready(input bit sel, input string tag);
    int n = 0;
    while (!(sel ? bus1.msg_ready : bus0.msg_ready) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, sel ? bus1.msg_ready : bus0.msg_ready, 1);
  endtask

  // Called just after an edge with ready high: the next edge accepts.
  task automatic send(input bit sel, input string tag, input logic on, input logic [3:0] ch,
                      input logic [6:0] note, input logic [6:0] vel);
    set_fields(on, ch, note, vel);
    if (sel) bus1.msg_valid = 1'b1; else bus0.msg_valid = 1'b1;
    tick();
    bus0.msg_valid = 1'b0;
    bus1.msg_valid = 1'b0;
    check({tag, "_acc_ready"}, sel ? bus1.msg_ready : bus0.msg_ready, 0);
    check({tag, "_acc_busy"},  sel ? b1 : b0, 1);
  endtask

  // Starts in cycle N+1 after accept; ends in the cycle after the message.
  task automatic expect_msg(input bit sel, input string tag, input int nb,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input bit toggle, input logic n_on, input logic [3:0] n_ch,
                            input logic [6:0] n_note, input logic [6:0] n_vel);
    logic [7:0] eb [3];
    logic [9:0] frame;
    logic       dv;
    int total, done_cnt, done_at, busy_lo, rdy_hi;
    eb[0] = e0; eb[1] = e1; eb[2] = e2;
    total = nb * 10 * CPB;
    done_cnt = 0; done_at = 0; busy_lo = 0; rdy_hi = 0;
    frame = '0;
    for (int c = 1; c <= total; c++) begin
      int k, byi, bi, ph;
      k   = (c - 1) / CPB;
      byi = k / 10;
      bi  = k % 10;
      ph  = (c - 1) % CPB;
      dv  = sel ? d1 : d0;
      if (ph == 0) frame[bi] = dv;
      else if (frame[bi] !== dv) frame[bi] = 1'bx;
      if (sel ? m1 : m0) begin done_cnt++; done_at = c; end
      if (!(sel ? b1 : b0)) busy_lo++;
      if (sel ? bus1.msg_ready : bus0.msg_ready) rdy_hi++;
      if (bi == 9 && ph == CPB - 1)
        check($sformatf("%s_frame%0d", tag, byi), {22'd0, frame}, {22'd0, 1'b1, eb[byi], 1'b0});
      if (toggle) begin
        if (c < total)
          set_fields(1'($urandom), 4'($urandom), 7'($urandom), 7'($urandom));
        else
          set_fields(n_on, n_ch, n_note, n_vel);
      end
      tick();
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_at"},  done_at, total);
    check({tag, "_busy_lo"},  busy_lo, 0);
    check({tag, "_rdy_hi"},   rdy_hi, 0);
    check({tag, "_end_ready"}, sel ? bus1.msg_ready : bus0.msg_ready, 1);
    check({tag, "_end_busy"},  sel ? b1 : b0, 0);
    check({tag, "_end_line"},  sel ? d1 : d0, 1);
    check({tag, "_end_done"},  sel ? m1 : m0, 0);
  endtask

  initial begin
    int done_seen;
    bus0.msg_valid = 1'b0;
    bus1.msg_valid = 1'b0;
    set_fields(1'b0, 4'd0, 7'd0, 7'd0);

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_line",  d0, 1);
    check("rst_ready", bus0.msg_ready, 0);
    check("rst_busy",  b0, 0);
    check("rst_done",  m0, 0);
    check("rst_line1", d1, 1);
    rst = 1'b0;
    tick();
    check("rel_ready",  bus0.msg_ready, 1);
    check("rel_ready1", bus1.msg_ready, 1);

    // Full message, then running-status compression, then status change
    wait_ready(0, "on60");
    send(0, "on60", 1'b1, 4'd0, 7'd60, 7'd100);
    expect_msg(0, "on60", 3, 8'h90, 8'h3C, 8'h64, 0, 0, 0, 0, 0);
    wait_ready(0, "on64");
    send(0, "on64", 1'b1, 4'd0, 7'd64, 7'd64);
    expect_msg(0, "on64", 2, 8'h40, 8'h40, 8'h00, 0, 0, 0, 0, 0);
    wait_ready(0, "off64");
    send(0, "off64", 1'b0, 4'd0, 7'd64, 7'd0);
    expect_msg(0, "off64", 3, 8'h80, 8'h40, 8'h00, 0, 0, 0, 0, 0);

    // Running status disabled: identical messages both carry status
    wait_ready(1, "rs0_a");
    send(1, "rs0_a", 1'b1, 4'd3, 7'd1, 7'd1);
    expect_msg(1, "rs0_a", 3, 8'h93, 8'h01, 8'h01, 0, 0, 0, 0, 0);
    wait_ready(1, "rs0_b");
    send(1, "rs0_b", 1'b1, 4'd3, 7'd1, 7'd1);
    expect_msg(1, "rs0_b", 3, 8'h93, 8'h01, 8'h01, 0, 0, 0, 0, 0);

    // valid held, fields churn during transmission, back-to-back second message
    wait_ready(0, "tgl_a");
    set_fields(1'b1, 4'd2, 7'd10, 7'd20);
    bus0.msg_valid = 1'b1;
    tick();
    check("tgl_a_acc_ready", bus0.msg_ready, 0);
    expect_msg(0, "tgl_a", 3, 8'h92, 8'h0A, 8'h14, 1, 1'b1, 4'd2, 7'd11, 7'd21);
    tick();
    bus0.msg_valid = 1'b0;
    check("tgl_b_acc_busy", b0, 1);
    expect_msg(0, "tgl_b", 2, 8'h0B, 8'h15, 8'h00, 0, 0, 0, 0, 0);

    // Reset in the middle of the status byte
    wait_ready(0, "mid");
    send(0, "mid", 1'b1, 4'd0, 7'd60, 7'd100);
    done_seen = 0;
    for (int c = 1; c < 55; c++) begin
      if (m0) done_seen++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (m0) done_seen++;
    check("mid_line",  d0, 1);
    check("mid_busy",  b0, 0);
    check("mid_ready", bus0.msg_ready, 0);
    tick();
    if (m0) done_seen++;
    check("mid_no_done", done_seen, 0);
    check("mid_ready_back", bus0.msg_ready, 1);
    send(0, "resend", 1'b1, 4'd0, 7'd60, 7'd100);
    expect_msg(0, "resend", 3, 8'h90, 8'h3C, 8'h64, 0, 0, 0, 0, 0);

    // Boundary field values
    wait_ready(0, "off127");
    send(0, "off127", 1'b0, 4'd15, 7'd127, 7'd0);
    expect_msg(0, "off127", 3, 8'h8F, 8'h7F, 8'h00, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
